// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encodings and the
// reset-cause codes that the SoC CSR decoder also interprets.
package reset_seq_pkg;

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2
   } state_e;

   localparam logic [1:0] CAUSE_EXT = 2'd0;
   localparam logic [1:0] CAUSE_SW  = 2'd1;
   localparam logic [1:0] CAUSE_WDT = 2'd2;

   // Width of a channel index; a single channel still needs one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/reset_seq_if.sv
// Control/status bundle between the reset sequencer and whoever drives it.
// The sequencer sits on the slave side; the host/watchdog logic is the master.
interface reset_seq_if #(
   parameter int N_CH = 3
);

   logic            sw_req;
   logic            wdt_en;
   logic            wdt_kick;
   logic [N_CH-1:0] rst_out;
   logic            ready;
   logic [1:0]      cause;

   modport master (
      output sw_req, wdt_en, wdt_kick,
      input  rst_out, ready, cause
   );

   modport slave (
      input  sw_req, wdt_en, wdt_kick,
      output rst_out, ready, cause
   );

endinterface

// File: rtl/reset_seq_sync.sv
// Two-flop synchroniser for the board reset: goes low the moment rst rises,
// and only reports release after a 1 has walked through both flops.
module reset_seq_sync (
   input  logic clk,
   input  logic rst,
   output logic released
);

   logic meta_q;
   logic sync_q;

   // Shift a constant 1 through the chain once rst has dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= 1'b1;
         sync_q <= meta_q;
      end
   end

   assign released = sync_q;

endmodule

// File: rtl/reset_seq.sv
// Reset sequencer: stretches the board reset, releases the reset channels one
// at a time with a fixed gap, then re-runs the sequence on a software request
// or watchdog expiry while remembering what caused the last reset.
module reset_seq
   import reset_seq_pkg::*;
#(
   parameter int N_CH         = 3,
   parameter int STRETCH_BITS = 5,
   parameter int GAP          = 4,
   parameter int WDT_BITS     = 24
) (
   input  logic        clk,
   input  logic        rst,
   reset_seq_if.slave  bus
);

   localparam int GAP_W = $clog2(GAP + 1);
   localparam int IDX_W = idx_width(N_CH);

   localparam logic [STRETCH_BITS-1:0] CNT_MAX  = {STRETCH_BITS{1'b1}};
   localparam logic [WDT_BITS-1:0]     WDT_MAX  = {WDT_BITS{1'b1}};
   localparam logic [GAP_W-1:0]        GAP_LAST = GAP_W'(GAP - 1);
   localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(N_CH - 1);

   logic                    released;
   state_e                  state_q,   state_d;
   logic [STRETCH_BITS-1:0] cnt_q,     cnt_d;
   logic [GAP_W-1:0]        gap_q,     gap_d;
   logic [IDX_W-1:0]        idx_q,     idx_d;
   logic [WDT_BITS-1:0]     wdt_q,     wdt_d;
   logic [N_CH-1:0]         rst_out_q, rst_out_d;
   logic                    ready_q,   ready_d;
   logic [1:0]              cause_q,   cause_d;
   logic                    wdt_expire;

   reset_seq_sync u_sync (
      .clk      (clk),
      .rst      (rst),
      .released (released)
   );

   // Watchdog runs only while in RUN with the enable high; a kick always wins over expiry.
   always_comb begin
      wdt_expire = 1'b0;
      wdt_d      = '0;
      if (state_q == ST_RUN && bus.wdt_en && !bus.wdt_kick) begin
         wdt_expire = (wdt_q == WDT_MAX);
         wdt_d      = wdt_q + 1'b1;
      end
   end

   // Sequencer next state: stretch in HOLD, release channels in RELEASE, watch for triggers in RUN.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      gap_d     = gap_q;
      idx_d     = idx_q;
      rst_out_d = rst_out_q;
      ready_d   = ready_q;
      cause_d   = cause_q;
      case (state_q)
         ST_HOLD: begin
            if (released) begin
               if (cnt_q == CNT_MAX) begin
                  rst_out_d[0] = 1'b0;
                  cnt_d        = '0;
                  gap_d        = '0;
                  if (N_CH == 1) begin
                     ready_d = 1'b1;
                     state_d = ST_RUN;
                  end else begin
                     idx_d   = IDX_W'(1);
                     state_d = ST_RELEASE;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_RELEASE: begin
            if (gap_q == GAP_LAST) begin
               gap_d = '0;
               for (int k = 0; k < N_CH; k++) begin
                  if (idx_q == IDX_W'(k)) begin
                     rst_out_d[k] = 1'b0;
                  end
               end
               if (idx_q == IDX_LAST) begin
                  ready_d = 1'b1;
                  state_d = ST_RUN;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         ST_RUN: begin
            if (bus.sw_req || wdt_expire) begin
               rst_out_d = '1;
               ready_d   = 1'b0;
               cnt_d     = '0;
               gap_d     = '0;
               idx_d     = '0;
               cause_d   = bus.sw_req ? CAUSE_SW : CAUSE_WDT;
               state_d   = ST_HOLD;
            end
         end
         default: begin
            state_d = ST_HOLD;
         end
      endcase
   end

   // State and output registers; the board reset forces everything back to the held state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_HOLD;
         cnt_q     <= '0;
         gap_q     <= '0;
         idx_q     <= '0;
         wdt_q     <= '0;
         rst_out_q <= '1;
         ready_q   <= 1'b0;
         cause_q   <= CAUSE_EXT;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         gap_q     <= gap_d;
         idx_q     <= idx_d;
         wdt_q     <= wdt_d;
         rst_out_q <= rst_out_d;
         ready_q   <= ready_d;
         cause_q   <= cause_d;
      end
   end

   assign bus.rst_out = rst_out_q;
   assign bus.ready   = ready_q;
   assign bus.cause   = cause_q;

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq with N_CH=3, STRETCH_BITS=4, GAP=2, WDT_BITS=6.
// Edges are counted from the first rising clock after the stimulus is applied.
module tb_reset_seq;

   localparam int N_CH         = 3;
   localparam int STRETCH_BITS = 4;
   localparam int GAP          = 2;
   localparam int WDT_BITS     = 6;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;

   reset_seq_if #(.N_CH(N_CH)) bus ();

   reset_seq #(
      .N_CH         (N_CH),
      .STRETCH_BITS (STRETCH_BITS),
      .GAP          (GAP),
      .WDT_BITS     (WDT_BITS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected channel vector when channel 0 falls at edge 'first'.
   function automatic logic [2:0] exp_seq(input int e, input int first);
      if (e < first)               return 3'b111;
      else if (e < first + GAP)    return 3'b110;
      else if (e < first + 2*GAP)  return 3'b100;
      else                         return 3'b000;
   endfunction

   task automatic test_reset();
      bus.sw_req   = 1'b0;
      bus.wdt_en   = 1'b0;
      bus.wdt_kick = 1'b0;
      #2 rst = 1'b1;
      #1;
      total++;
      if ({bus.rst_out, bus.ready, bus.cause} !== 6'b111_0_00) begin
         bad++;
         $display("[TB] FAIL reset_async: rst_out=%b ready=%b cause=%0d expected 111/0/0", bus.rst_out, bus.ready, bus.cause);
      end
      repeat (5) tick();
      total++;
      if ({bus.rst_out, bus.ready, bus.cause} !== 6'b111_0_00) begin
         bad++;
         $display("[TB] FAIL reset_held: rst_out=%b ready=%b cause=%0d expected 111/0/0", bus.rst_out, bus.ready, bus.cause);
      end
   endtask

   task automatic test_power_on();
      rst = 1'b0;
      for (int e = 1; e <= 22; e++) begin
         tick();
         total++;
         if (bus.rst_out !== exp_seq(e, 18) || bus.ready !== (e >= 22)) begin
            bad++;
            $display("[TB] FAIL power_on edge %0d: rst_out=%b ready=%b expected %b/%b", e, bus.rst_out, bus.ready, exp_seq(e, 18), (e >= 22));
         end
      end
      total++;
      if (bus.cause !== 2'd0) begin
         bad++;
         $display("[TB] FAIL power_on_cause: cause=%0d expected 0", bus.cause);
      end
   endtask

   task automatic test_sw_reset();
      for (int e = 1; e <= 21; e++) begin
         bus.sw_req = (e == 1);
         tick();
         total++;
         if (bus.rst_out !== exp_seq(e, 17) || bus.ready !== (e >= 21)) begin
            bad++;
            $display("[TB] FAIL sw_reset edge %0d: rst_out=%b ready=%b expected %b/%b", e, bus.rst_out, bus.ready, exp_seq(e, 17), (e >= 21));
         end
         if (e == 1) begin
            total++;
            if (bus.cause !== 2'd1) begin
               bad++;
               $display("[TB] FAIL sw_cause: cause=%0d expected 1", bus.cause);
            end
         end
      end
      bus.sw_req = 1'b0;
   endtask

   task automatic test_watchdog();
      for (int e = 1; e <= 84; e++) begin
         bus.wdt_en = (e < 70);
         tick();
         total++;
         if (e < 64) begin
            if (bus.rst_out !== 3'b000 || bus.ready !== 1'b1) begin
               bad++;
               $display("[TB] FAIL wdt_run edge %0d: rst_out=%b ready=%b expected 000/1", e, bus.rst_out, bus.ready);
            end
         end else if (bus.rst_out !== exp_seq(e - 63, 17) || bus.ready !== (e >= 84)) begin
            bad++;
            $display("[TB] FAIL wdt_reseq edge %0d: rst_out=%b ready=%b expected %b/%b", e, bus.rst_out, bus.ready, exp_seq(e - 63, 17), (e >= 84));
         end
         if (e == 64) begin
            total++;
            if (bus.cause !== 2'd2) begin
               bad++;
               $display("[TB] FAIL wdt_cause: cause=%0d expected 2", bus.cause);
            end
         end
      end
      bus.wdt_en = 1'b0;
   endtask

   task automatic test_kick();
      bus.wdt_en = 1'b1;
      for (int c = 1; c <= 1000; c++) begin
         bus.wdt_kick = (c % 50 == 0);
         tick();
         total++;
         if (bus.rst_out !== 3'b000 || bus.ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL kick_run cycle %0d: rst_out=%b ready=%b expected 000/1", c, bus.rst_out, bus.ready);
         end
      end
      // Kick lands exactly on the expiry edge, then the counter restarts from zero.
      for (int c = 1; c <= 148; c++) begin
         bus.wdt_kick = (c == 64);
         bus.wdt_en   = (c < 130);
         tick();
         total++;
         if (c < 128) begin
            if (bus.rst_out !== 3'b000 || bus.ready !== 1'b1) begin
               bad++;
               $display("[TB] FAIL kick_expiry cycle %0d: rst_out=%b ready=%b expected 000/1", c, bus.rst_out, bus.ready);
            end
         end else if (bus.rst_out !== exp_seq(c - 127, 17) || bus.ready !== (c >= 148)) begin
            bad++;
            $display("[TB] FAIL kick_restart cycle %0d: rst_out=%b ready=%b expected %b/%b", c, bus.rst_out, bus.ready, exp_seq(c - 127, 17), (c >= 148));
         end
         if (c == 128) begin
            total++;
            if (bus.cause !== 2'd2) begin
               bad++;
               $display("[TB] FAIL kick_cause: cause=%0d expected 2", bus.cause);
            end
         end
      end
      bus.wdt_kick = 1'b0;
      bus.wdt_en   = 1'b0;
   endtask

   task automatic test_priority();
      for (int e = 1; e <= 84; e++) begin
         bus.wdt_en = (e < 70);
         bus.sw_req = (e == 64);
         tick();
         total++;
         if (e < 64) begin
            if (bus.rst_out !== 3'b000) begin
               bad++;
               $display("[TB] FAIL prio_run edge %0d: rst_out=%b expected 000", e, bus.rst_out);
            end
         end else if (bus.rst_out !== exp_seq(e - 63, 17) || bus.ready !== (e >= 84)) begin
            bad++;
            $display("[TB] FAIL prio_reseq edge %0d: rst_out=%b ready=%b expected %b/%b", e, bus.rst_out, bus.ready, exp_seq(e - 63, 17), (e >= 84));
         end
         if (e == 64) begin
            total++;
            if (bus.cause !== 2'd1) begin
               bad++;
               $display("[TB] FAIL prio_cause: cause=%0d expected 1", bus.cause);
            end
         end
      end
      bus.sw_req = 1'b0;
      bus.wdt_en = 1'b0;
   endtask

   task automatic test_ignore();
      for (int e = 1; e <= 21; e++) begin
         bus.sw_req = (e == 1 || e == 6 || e == 19);
         tick();
         total++;
         if (bus.rst_out !== exp_seq(e, 17) || bus.ready !== (e >= 21)) begin
            bad++;
            $display("[TB] FAIL ignore edge %0d: rst_out=%b ready=%b expected %b/%b", e, bus.rst_out, bus.ready, exp_seq(e, 17), (e >= 21));
         end
      end
      bus.sw_req = 1'b0;
   endtask

   task automatic test_async_abort();
      for (int e = 1; e <= 18; e++) begin
         bus.sw_req = (e == 1);
         tick();
      end
      bus.sw_req = 1'b0;
      total++;
      if (bus.rst_out !== 3'b110 || bus.cause !== 2'd1) begin
         bad++;
         $display("[TB] FAIL abort_pre: rst_out=%b cause=%0d expected 110/1", bus.rst_out, bus.cause);
      end
      #3 rst = 1'b1;
      #1;
      total++;
      if ({bus.rst_out, bus.ready, bus.cause} !== 6'b111_0_00) begin
         bad++;
         $display("[TB] FAIL abort_async: rst_out=%b ready=%b cause=%0d expected 111/0/0", bus.rst_out, bus.ready, bus.cause);
      end
      tick();
      tick();
      rst = 1'b0;
      for (int e = 1; e <= 22; e++) begin
         tick();
         total++;
         if (bus.rst_out !== exp_seq(e, 18) || bus.ready !== (e >= 22)) begin
            bad++;
            $display("[TB] FAIL abort_reseq edge %0d: rst_out=%b ready=%b expected %b/%b", e, bus.rst_out, bus.ready, exp_seq(e, 18), (e >= 22));
         end
      end
      total++;
      if (bus.cause !== 2'd0) begin
         bad++;
         $display("[TB] FAIL abort_cause: cause=%0d expected 0", bus.cause);
      end
   endtask

   initial begin
      $display("[TB] reset_seq directed tests starting");
      test_reset();
      test_power_on();
      test_sw_reset();
      test_watchdog();
      test_kick();
      test_priority();
      test_ignore();
      test_async_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
